// File: rtl/rvfi_commit_tracker_pkg.sv
// Shared types for the RVFI commit tracker: the per-instruction packet that
// travels alongside the pipeline, its empty value, and a small x0 helper.
package rvfi_commit_tracker_pkg;

   typedef struct packed {
      logic        valid;
      logic [31:0] inst;
      logic [31:0] pc_rdata;
      logic [31:0] pc_wdata;
      logic [4:0]  rs1_addr;
      logic [4:0]  rs2_addr;
      logic [31:0] rs1_rdata;
      logic [31:0] rs2_rdata;
      logic        load_regfile;
      logic [4:0]  rd_addr;
      logic [31:0] rd_wdata;
      logic [31:0] mem_addr;
      logic [3:0]  rmask;
      logic [3:0]  wmask;
      logic [31:0] mem_rdata;
      logic [31:0] mem_wdata;
   } rvfi_pkt_t;

   localparam rvfi_pkt_t RVFI_NOP = '0;

   // Register x0 always reads and writes as zero, whatever the datapath carried.
   function automatic logic [31:0] zero_if_x0(input logic [4:0] addr, input logic [31:0] data);
      return (addr == 5'd0) ? 32'd0 : data;
   endfunction

endpackage

// File: rtl/rvfi_commit_tracker_if.sv
// RVFI monitor bus: the tracker drives it (master), the formal/sim monitor samples it (slave).
interface rvfi_commit_tracker_if #(
   parameter int ORDER_W = 64
);
   logic               rvfi_commit;
   logic [ORDER_W-1:0] rvfi_order;
   logic               rvfi_halt;
   logic [31:0]        rvfi_inst;
   logic [31:0]        rvfi_pc_rdata;
   logic [31:0]        rvfi_pc_wdata;
   logic [4:0]         rvfi_rs1_addr;
   logic [4:0]         rvfi_rs2_addr;
   logic [31:0]        rvfi_rs1_rdata;
   logic [31:0]        rvfi_rs2_rdata;
   logic               rvfi_load_regfile;
   logic [4:0]         rvfi_rd_addr;
   logic [31:0]        rvfi_rd_wdata;
   logic [31:0]        rvfi_mem_addr;
   logic [3:0]         rvfi_rmask;
   logic [3:0]         rvfi_wmask;
   logic [31:0]        rvfi_mem_rdata;
   logic [31:0]        rvfi_mem_wdata;

   modport master (
      output rvfi_commit, rvfi_order, rvfi_halt, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_load_regfile,
             rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_rmask, rvfi_wmask,
             rvfi_mem_rdata, rvfi_mem_wdata
   );

   modport slave (
      input  rvfi_commit, rvfi_order, rvfi_halt, rvfi_inst, rvfi_pc_rdata, rvfi_pc_wdata,
             rvfi_rs1_addr, rvfi_rs2_addr, rvfi_rs1_rdata, rvfi_rs2_rdata, rvfi_load_regfile,
             rvfi_rd_addr, rvfi_rd_wdata, rvfi_mem_addr, rvfi_rmask, rvfi_wmask,
             rvfi_mem_rdata, rvfi_mem_wdata
   );
endinterface

// File: rtl/rvfi_commit_tracker_slot.sv
// One shadow pipeline slot: holds a packet under pause, and can kill the
// incoming instruction's valid bit as it is loaded.
module rvfi_commit_tracker_slot
   import rvfi_commit_tracker_pkg::*;
(
   input  logic      clk,
   input  logic      rst,
   input  logic      pause,
   input  logic      kill,
   input  rvfi_pkt_t d,
   output rvfi_pkt_t q
);

   always_ff @(posedge clk) begin
      if (rst) begin
         q <= RVFI_NOP;
      end else if (!pause) begin
         q       <= d;
         q.valid <= d.valid & ~kill;
      end
   end

endmodule

// File: rtl/rvfi_commit_tracker.sv
// Shadows each instruction through EX/MEM/WB, merging stage-local fields into
// one RVFI packet, and publishes it on the monitor bus when it retires.
module rvfi_commit_tracker
   import rvfi_commit_tracker_pkg::*;
#(
   parameter int ORDER_W     = 64,
   parameter bit HALT_ENABLE = 1'b1
)(
   input  logic        clk,
   input  logic        rst,
   input  logic        pause,
   input  logic        flush,
   input  logic        id_valid,
   input  logic [31:0] id_inst,
   input  logic [31:0] id_pc,
   input  logic [4:0]  ex_rs1_addr,
   input  logic [4:0]  ex_rs2_addr,
   input  logic [31:0] ex_rs1_data,
   input  logic [31:0] ex_rs2_data,
   input  logic [31:0] ex_pc_next,
   input  logic [31:0] mem_addr,
   input  logic [3:0]  mem_rmask,
   input  logic [3:0]  mem_wmask,
   input  logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_resp,
   input  logic        wb_load,
   input  logic [4:0]  wb_rd,
   input  logic [31:0] wb_wdata,
   rvfi_commit_tracker_if.master rvfi
);

   rvfi_pkt_t          ex_d, ex_q;
   rvfi_pkt_t          mem_d, mem_q;
   rvfi_pkt_t          wb_d, wb_q;
   rvfi_pkt_t          ret;
   logic [31:0]        rdata_shadow;
   logic [ORDER_W-1:0] order_q;
   logic               halt_done;
   logic               commit;
   logic               halt;

   always_comb begin
      ex_d          = RVFI_NOP;
      ex_d.valid    = id_valid;
      ex_d.inst     = id_inst;
      ex_d.pc_rdata = id_pc;

      mem_d           = ex_q;
      mem_d.rs1_addr  = ex_rs1_addr;
      mem_d.rs2_addr  = ex_rs2_addr;
      mem_d.rs1_rdata = ex_rs1_data;
      mem_d.rs2_rdata = ex_rs2_data;
      mem_d.pc_wdata  = ex_pc_next;

      // A load may see its response while stalled; the shadow covers that case.
      wb_d           = mem_q;
      wb_d.mem_addr  = mem_addr;
      wb_d.rmask     = mem_rmask;
      wb_d.wmask     = mem_wmask;
      wb_d.mem_wdata = mem_wdata;
      if (mem_rmask == 4'd0) begin
         wb_d.mem_rdata = 32'd0;
      end else if (mem_resp) begin
         wb_d.mem_rdata = mem_rdata;
      end else begin
         wb_d.mem_rdata = rdata_shadow;
      end
   end

   rvfi_commit_tracker_slot u_slot_ex (
      .clk   (clk),
      .rst   (rst),
      .pause (pause),
      .kill  (flush),
      .d     (ex_d),
      .q     (ex_q)
   );

   rvfi_commit_tracker_slot u_slot_mem (
      .clk   (clk),
      .rst   (rst),
      .pause (pause),
      .kill  (1'b0),
      .d     (mem_d),
      .q     (mem_q)
   );

   rvfi_commit_tracker_slot u_slot_wb (
      .clk   (clk),
      .rst   (rst),
      .pause (pause),
      .kill  (1'b0),
      .d     (wb_d),
      .q     (wb_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_shadow <= 32'd0;
      end else if (mem_q.valid && mem_resp) begin
         rdata_shadow <= mem_rdata;
      end
   end

   assign commit = wb_q.valid & ~pause & ~rst;

   always_comb begin
      ret = RVFI_NOP;
      if (commit) begin
         ret              = wb_q;
         ret.rs1_rdata    = zero_if_x0(wb_q.rs1_addr, wb_q.rs1_rdata);
         ret.rs2_rdata    = zero_if_x0(wb_q.rs2_addr, wb_q.rs2_rdata);
         ret.load_regfile = wb_load;
         ret.rd_addr      = wb_rd;
         ret.rd_wdata     = zero_if_x0(wb_rd, wb_wdata);
      end
      ret.valid = commit;
   end

   assign halt = HALT_ENABLE && ret.valid && (ret.pc_wdata == ret.pc_rdata) && !halt_done;

   // Order names the retiring instruction, so it advances only after the commit cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         order_q   <= '0;
         halt_done <= 1'b0;
      end else begin
         if (commit) begin
            order_q <= order_q + ORDER_W'(1);
         end
         if (halt) begin
            halt_done <= 1'b1;
         end
      end
   end

   assign rvfi.rvfi_commit       = ret.valid;
   assign rvfi.rvfi_order        = order_q;
   assign rvfi.rvfi_halt         = halt;
   assign rvfi.rvfi_inst         = ret.inst;
   assign rvfi.rvfi_pc_rdata     = ret.pc_rdata;
   assign rvfi.rvfi_pc_wdata     = ret.pc_wdata;
   assign rvfi.rvfi_rs1_addr     = ret.rs1_addr;
   assign rvfi.rvfi_rs2_addr     = ret.rs2_addr;
   assign rvfi.rvfi_rs1_rdata    = ret.rs1_rdata;
   assign rvfi.rvfi_rs2_rdata    = ret.rs2_rdata;
   assign rvfi.rvfi_load_regfile = ret.load_regfile;
   assign rvfi.rvfi_rd_addr      = ret.rd_addr;
   assign rvfi.rvfi_rd_wdata     = ret.rd_wdata;
   assign rvfi.rvfi_mem_addr     = ret.mem_addr;
   assign rvfi.rvfi_rmask        = ret.rmask;
   assign rvfi.rvfi_wmask        = ret.wmask;
   assign rvfi.rvfi_mem_rdata    = ret.mem_rdata;
   assign rvfi.rvfi_mem_wdata    = ret.mem_wdata;

endmodule
